// File: rtl/perceptron_train_ctrl_pkg.sv
// Shared parameters, types and weight arithmetic for the perceptron training path.
package perceptron_pkg;

  localparam int unsigned PERCEPTRON_NUMBER = 64;
  localparam int unsigned WEIGHT_NUMBER     = 65;
  localparam int unsigned HISTORY_SIZE      = 64;
  localparam int unsigned WIDTH             = 8;
  localparam int unsigned SUM_WIDTH         = 16;
  localparam int unsigned THETA             = 137;
  localparam int unsigned FIFO_DEPTH        = 4;

  localparam int unsigned INDEX_W = $clog2(PERCEPTRON_NUMBER);
  localparam int unsigned ROW_W   = WEIGHT_NUMBER * WIDTH;
  localparam int unsigned CNT_W   = $clog2(FIFO_DEPTH) + 1;

  typedef logic signed [WIDTH-1:0] weight_t;
  // weight j occupies bits [j*WIDTH +: WIDTH]
  typedef weight_t [WEIGHT_NUMBER-1:0] row_t;

  typedef enum logic [1:0] {S_IDLE, S_RD, S_CALC, S_WR} state_t;

  typedef struct packed {
    logic [INDEX_W-1:0]      index;
    logic [HISTORY_SIZE-1:0] history;
    logic                    taken;
  } upd_t;

  localparam weight_t W_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam weight_t W_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  // Saturating +1 / -1 on one weight.
  function automatic weight_t sat_step(weight_t w, logic up);
    if (up) return (w == W_MAX) ? w : w + weight_t'(1);
    else    return (w == W_MIN) ? w : w - weight_t'(1);
  endfunction

  // Train on a misprediction or a low-confidence output; magnitude is taken
  // one bit wider so the most negative sum does not wrap.
  function automatic logic needs_train(logic signed [SUM_WIDTH-1:0] sum, logic taken);
    logic signed [SUM_WIDTH:0] ext;
    logic        [SUM_WIDTH:0] mag;
    logic                      pred;
    ext  = {sum[SUM_WIDTH-1], sum};
    mag  = ext[SUM_WIDTH] ? $unsigned(-ext) : $unsigned(ext);
    pred = ~sum[SUM_WIDTH-1];
    return (pred != taken) || (mag <= (SUM_WIDTH+1)'(THETA));
  endfunction

endpackage

// File: rtl/perceptron_train_ctrl_if.sv
// Resolved-branch record channel from the back end.
interface perceptron_train_ctrl_if;
  import perceptron_pkg::*;

  logic                        res_valid;
  logic                        res_ready;
  logic [INDEX_W-1:0]          res_index;
  logic [HISTORY_SIZE-1:0]     res_history;
  logic                        res_taken;
  logic signed [SUM_WIDTH-1:0] res_sum;

  modport master (output res_valid, res_index, res_history, res_taken, res_sum,
                  input  res_ready);
  modport slave  (input  res_valid, res_index, res_history, res_taken, res_sum,
                  output res_ready);
endinterface

// File: rtl/perceptron_train_ctrl_fifo.sv
// Synchronous FIFO holding pending training updates.
module perceptron_update_fifo #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned DATA_W = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    push,
  input  logic [DATA_W-1:0]       din,
  input  logic                    pop,
  output logic [DATA_W-1:0]       dout,
  output logic                    full,
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  count
);
  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign full    = (count == (PTR_W+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Storage; validity is tracked by count, so no reset is needed here.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers and occupancy.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);
    end
  end
endmodule

// File: rtl/perceptron_train_ctrl.sv
// Perceptron weight-table training sequencer: filter, queue, read-modify-write.
module perceptron_train_ctrl
  import perceptron_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  perceptron_train_ctrl_if.slave  res,
  input  logic                    pred_rd_req,
  output logic                    tbl_rd_en,
  output logic [INDEX_W-1:0]      tbl_rd_index,
  input  logic [ROW_W-1:0]        tbl_rd_row,
  output logic                    tbl_wr_en,
  output logic [INDEX_W-1:0]      tbl_wr_index,
  output logic [ROW_W-1:0]        tbl_wr_row,
  output logic                    busy
);
  state_t            state_q, state_d;
  upd_t              push_rec, head, work_q;
  row_t              row_in, row_calc, row_q;
  logic              fifo_full, fifo_empty;
  logic [CNT_W-1:0]  fifo_count, count_next;
  logic              push, rd_go, ready_q;

  assign push_rec = '{index: res.res_index, history: res.res_history, taken: res.res_taken};
  assign push     = res.res_valid && ready_q && !fifo_full
                    && needs_train(res.res_sum, res.res_taken);

  perceptron_update_fifo #(
    .DEPTH  (FIFO_DEPTH),
    .DATA_W ($bits(upd_t))
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   (push_rec),
    .pop   (rd_go),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Ready is registered, so it is derived from the occupancy after this edge.
  assign count_next = fifo_count + CNT_W'(push) - CNT_W'(rd_go);

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next state and table strobes; lookups always win the read port.
  always_comb begin
    state_d   = state_q;
    rd_go     = 1'b0;
    tbl_wr_en = 1'b0;
    unique case (state_q)
      S_IDLE: if (!fifo_empty && !pred_rd_req) begin
        rd_go   = 1'b1;
        state_d = S_RD;
      end
      S_RD:   state_d = S_CALC;
      S_CALC: state_d = S_WR;
      S_WR: begin
        tbl_wr_en = 1'b1;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign tbl_rd_en    = rd_go;
  assign tbl_rd_index = rd_go ? head.index : '0;
  assign tbl_wr_index = work_q.index;
  assign tbl_wr_row   = row_q;
  assign busy         = !fifo_empty || (state_q != S_IDLE);
  assign res.res_ready = ready_q;

  // New row from the data returned one cycle after the read.
  assign row_in = tbl_rd_row;
  always_comb begin
    row_calc    = row_in;
    row_calc[0] = sat_step(row_in[0], work_q.taken);
    for (int unsigned j = 1; j < WEIGHT_NUMBER; j++)
      row_calc[j] = sat_step(row_in[j], work_q.history[j-1] == work_q.taken);
  end

  // Working record, computed row and registered ready.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      work_q  <= '0;
      row_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      ready_q <= (count_next != CNT_W'(FIFO_DEPTH));
      if (rd_go) work_q <= head;
      if (state_q == S_RD) row_q <= row_calc;
    end
  end
endmodule

// File: tb/tb_perceptron_train_ctrl.sv
// Self-checking bench for perceptron_train_ctrl with a table model and scoreboard.
module tb_perceptron_train_ctrl;
  import perceptron_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic pred_rd_req = 1'b0;
  logic tbl_rd_en, tbl_wr_en, busy;
  logic [INDEX_W-1:0] tbl_rd_index, tbl_wr_index;
  logic [ROW_W-1:0]   tbl_rd_row, tbl_wr_row;

  perceptron_train_ctrl_if res_if();

  perceptron_train_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .res          (res_if),
    .pred_rd_req  (pred_rd_req),
    .tbl_rd_en    (tbl_rd_en),
    .tbl_rd_index (tbl_rd_index),
    .tbl_rd_row   (tbl_rd_row),
    .tbl_wr_en    (tbl_wr_en),
    .tbl_wr_index (tbl_wr_index),
    .tbl_wr_row   (tbl_wr_row),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [ROW_W-1:0] act, input logic [ROW_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Weight table model: one-cycle read latency, write lands at the edge.
  logic [ROW_W-1:0]   tbl [PERCEPTRON_NUMBER];
  logic               pre_en = 1'b0;
  logic [INDEX_W-1:0] pre_idx;
  logic [ROW_W-1:0]   pre_row;
  always @(posedge clk) begin
    if (tbl_wr_en) tbl[tbl_wr_index] <= tbl_wr_row;
    if (tbl_rd_en) tbl_rd_row <= tbl[tbl_rd_index];
    if (pre_en)    tbl[pre_idx] <= pre_row;
  end

  // Reference rules in plain integer arithmetic.
  function automatic bit model_train(logic signed [SUM_WIDTH-1:0] s, logic t);
    int v, mag;
    bit pred;
    v    = s;
    pred = (v >= 0);
    mag  = (v < 0) ? -v : v;
    return (pred != t) || (mag <= int'(THETA));
  endfunction

  function automatic logic [ROW_W-1:0] model_row(logic [ROW_W-1:0] old,
                                                 logic [HISTORY_SIZE-1:0] h, logic t);
    logic [ROW_W-1:0] r;
    int w, hi, lo;
    hi = (1 << (WIDTH-1)) - 1;
    lo = -(1 << (WIDTH-1));
    for (int j = 0; j < int'(WEIGHT_NUMBER); j++) begin
      w = $signed(old[j*WIDTH +: WIDTH]);
      if (j == 0) w += t ? 1 : -1;
      else        w += (h[j-1] == t) ? 1 : -1;
      if (w > hi) w = hi;
      if (w < lo) w = lo;
      r[j*WIDTH +: WIDTH] = w[WIDTH-1:0];
    end
    return r;
  endfunction

  typedef struct {
    logic [INDEX_W-1:0]      idx;
    logic [HISTORY_SIZE-1:0] hist;
    logic                    taken;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   rd_count = 0, wr_count = 0, wr_any = 0;
  int   rd_cyc[$], wr_cyc[$];
  int   wr_idx_log[$];

  // Scoreboard: record accepted work, compare every write against the model.
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (tbl_wr_en) wr_any++;
    if (!rst_n) exp_q.delete();
    else begin
      if (res_if.res_valid && res_if.res_ready && model_train(res_if.res_sum, res_if.res_taken)) begin
        e.idx = res_if.res_index; e.hist = res_if.res_history; e.taken = res_if.res_taken;
        exp_q.push_back(e);
      end
      if (tbl_rd_en) begin
        rd_count++;
        rd_cyc.push_back(cyc);
        chk("rd_while_pred_req", pred_rd_req, 1'b0);
      end
      if (tbl_wr_en) begin
        wr_count++;
        wr_cyc.push_back(cyc);
        wr_idx_log.push_back(int'(tbl_wr_index));
        if (exp_q.size() == 0) chk("unexpected_write", 1'b1, 1'b0);
        else begin
          e = exp_q.pop_front();
          chk("sb_wr_index", tbl_wr_index, e.idx);
          chk("sb_wr_row", tbl_wr_row, model_row(tbl[e.idx], e.hist, e.taken));
        end
      end
    end
  end

  task automatic drive(input int idx, input logic [HISTORY_SIZE-1:0] h, input logic t,
                       input int s);
    res_if.res_index   = idx[INDEX_W-1:0];
    res_if.res_history = h;
    res_if.res_taken   = t;
    res_if.res_sum     = s[SUM_WIDTH-1:0];
    res_if.res_valid   = 1'b1;
  endtask

  task automatic send(input int idx, input logic [HISTORY_SIZE-1:0] h, input logic t, input int s);
    bit acc = 0;
    drive(idx, h, t, s);
    for (int k = 0; k < 200 && !acc; k++) begin
      @(negedge clk);
      if (res_if.res_ready) acc = 1;
      @(posedge clk); #1;
    end
    res_if.res_valid = 1'b0;
    chk("send_accepted", acc, 1'b1);
  endtask

  task automatic set_row(input int idx, input logic [ROW_W-1:0] r);
    pre_idx = idx[INDEX_W-1:0];
    pre_row = r;
    pre_en  = 1'b1;
    @(posedge clk); #1;
    pre_en  = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy !== 1'b0 || exp_q.size() != 0) && n < 200) begin
      @(negedge clk); n++;
    end
    chk("reach_idle_busy", busy, 1'b0);
    chk("reach_idle_pending", exp_q.size(), 0);
  endtask

  task automatic wait_writes(input int target);
    int n = 0;
    while (wr_count < target && n < 200) begin
      @(negedge clk); n++;
    end
    chk("write_count", wr_count, target);
  endtask

  function automatic logic [ROW_W-1:0] rand_row();
    logic [ROW_W-1:0] r;
    for (int j = 0; j < int'(WEIGHT_NUMBER); j++) begin
      case ($urandom_range(0, 7))
        0:       r[j*WIDTH +: WIDTH] = W_MAX;
        1:       r[j*WIDTH +: WIDTH] = W_MIN;
        default: r[j*WIDTH +: WIDTH] = WIDTH'($urandom);
      endcase
    end
    return r;
  endfunction

  typedef struct {
    int   sum;
    logic taken;
    logic exp_train;
  } filt_vec_t;

  filt_vec_t fv[12];

  initial begin
    logic [ROW_W-1:0] ones_row, sat_row;
    logic [HISTORY_SIZE-1:0] h;
    int w0, r0, wa;

    fv[0]  = '{-5,     1'b1, 1'b1};
    fv[1]  = '{200,    1'b1, 1'b0};
    fv[2]  = '{137,    1'b1, 1'b1};
    fv[3]  = '{138,    1'b1, 1'b0};
    fv[4]  = '{-138,   1'b0, 1'b0};
    fv[5]  = '{-137,   1'b0, 1'b1};
    fv[6]  = '{0,      1'b0, 1'b1};
    fv[7]  = '{0,      1'b1, 1'b1};
    fv[8]  = '{-32768, 1'b0, 1'b0};
    fv[9]  = '{32767,  1'b1, 1'b0};
    fv[10] = '{-32768, 1'b1, 1'b1};
    fv[11] = '{200,    1'b0, 1'b1};

    res_if.res_valid = 1'b0;
    res_if.res_index = '0; res_if.res_history = '0; res_if.res_taken = 1'b0; res_if.res_sum = '0;

    // Reset with table initialisation.
    repeat (2) @(posedge clk); #1;
    for (int i = 0; i < int'(PERCEPTRON_NUMBER); i++) set_row(i, rand_row());
    set_row(3, '0);
    set_row(7, '0);
    sat_row = '0;
    sat_row[0*WIDTH +: WIDTH] = W_MAX;
    sat_row[5*WIDTH +: WIDTH] = W_MIN;
    set_row(10, sat_row);
    @(negedge clk);
    chk("rst_ready", res_if.res_ready, 1'b0);
    chk("rst_strobes", {tbl_rd_en, tbl_wr_en, busy}, 3'b000);
    chk("rst_indices", {tbl_rd_index, tbl_wr_index}, '0);
    chk("rst_wr_row", tbl_wr_row, '0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("post_rst_ready", res_if.res_ready, 1'b1);

    // Latency: accept at t, read at t+1, write at t+4.
    for (int j = 0; j < int'(WEIGHT_NUMBER); j++) ones_row[j*WIDTH +: WIDTH] = 8'h01;
    @(posedge clk); #1;
    drive(3, '1, 1'b1, -5);
    @(negedge clk); chk("lat_accept", res_if.res_ready, 1'b1);
    @(posedge clk); #1 res_if.res_valid = 1'b0;
    @(negedge clk); chk("lat_rd_en_t1", tbl_rd_en, 1'b1); chk("lat_rd_index", tbl_rd_index, 3);
    @(negedge clk); chk("lat_quiet_t2", {tbl_rd_en, tbl_wr_en}, 2'b00);
    @(negedge clk); chk("lat_quiet_t3", {tbl_rd_en, tbl_wr_en}, 2'b00);
    @(negedge clk);
    chk("lat_wr_en_t4", tbl_wr_en, 1'b1);
    chk("lat_wr_index", tbl_wr_index, 3);
    chk("lat_wr_row", tbl_wr_row, ones_row);
    wait_idle();

    // Training filter table.
    foreach (fv[i]) begin
      w0 = wr_count;
      @(posedge clk); #1;
      send(30, {$urandom, $urandom}, fv[i].taken, fv[i].sum);
      if (!fv[i].exp_train) begin
        @(negedge clk); chk("drop_busy", busy, 1'b0);
      end
      repeat (6) @(negedge clk);
      chk("filter_write_count", wr_count - w0, fv[i].exp_train);
      wait_idle();
    end

    // Saturation at both ends.
    w0 = wr_count;
    h = '1; h[4] = 1'b0;
    @(posedge clk); #1;
    send(10, h, 1'b1, -5);
    wait_writes(w0 + 1);
    @(posedge clk); @(negedge clk);
    chk("sat_w0", tbl[10][0*WIDTH +: WIDTH], 8'h7F);
    chk("sat_w5", tbl[10][5*WIDTH +: WIDTH], 8'h80);
    chk("sat_w1", tbl[10][1*WIDTH +: WIDTH], 8'h01);
    wait_idle();

    // Backpressure with the read port held by lookups.
    w0 = wr_count; r0 = rd_count;
    @(posedge clk); #1 pred_rd_req = 1'b1;
    for (int k = 0; k < 4; k++) send(20 + k, {$urandom, $urandom}, 1'b0, 1);
    drive(24, '0, 1'b0, 1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); chk("full_ready_low", res_if.res_ready, 1'b0);
    end
    @(posedge clk); #1 res_if.res_valid = 1'b0;
    chk("no_rd_while_held", rd_count, r0);
    chk("busy_while_held", busy, 1'b1);
    pred_rd_req = 1'b0;
    wait_writes(w0 + 4);
    for (int k = 0; k < 4; k++) chk("fifo_order", wr_idx_log[w0 + k], 20 + k);
    wait_idle();
    chk("no_fifth_write", wr_count, w0 + 4);

    // Same row twice: second read follows the first write.
    w0 = wr_cyc.size(); r0 = rd_cyc.size();
    @(posedge clk); #1;
    send(7, '0, 1'b1, -5);
    send(7, '0, 1'b1, -5);
    wait_writes(wr_count + (2 - (wr_count - w0)));
    @(posedge clk); @(negedge clk);
    chk("serial_rd_after_wr", rd_cyc[r0 + 1] > wr_cyc[w0], 1'b1);
    chk("serial_bias", tbl[7][0*WIDTH +: WIDTH], 8'h02);
    chk("serial_w1", tbl[7][1*WIDTH +: WIDTH], 8'hFE);
    wait_idle();

    // Reset in the cycle after the read: the update is dropped.
    @(posedge clk); #1;
    drive(40, {$urandom, $urandom}, 1'b0, 3);
    @(negedge clk); chk("rstmid_accept", res_if.res_ready, 1'b1);
    @(posedge clk); #1 res_if.res_valid = 1'b0;
    @(negedge clk); chk("rstmid_rd_en", tbl_rd_en, 1'b1);
    @(posedge clk); #1 rst_n = 1'b0;
    wa = wr_any;
    @(posedge clk); @(negedge clk);
    chk("rstmid_strobes", {tbl_rd_en, tbl_wr_en}, 2'b00);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("rstmid_busy", busy, 1'b0);
    chk("rstmid_ready", res_if.res_ready, 1'b1);
    repeat (6) @(negedge clk);
    chk("rstmid_no_write", wr_any, wa);

    // Randomised traffic against the scoreboard.
    @(posedge clk); #1;
    for (int c = 0; c < 400; c++) begin
      pred_rd_req      = ($urandom_range(0, 3) == 0);
      res_if.res_valid = $urandom_range(0, 1);
      res_if.res_index = INDEX_W'($urandom_range(0, 7));
      res_if.res_history = {$urandom, $urandom};
      res_if.res_taken = $urandom_range(0, 1);
      res_if.res_sum   = ($urandom_range(0, 1) == 1) ? SUM_WIDTH'($urandom_range(0, 400) - 200)
                                                     : SUM_WIDTH'($urandom);
      @(posedge clk); #1;
    end
    res_if.res_valid = 1'b0;
    pred_rd_req = 1'b0;
    wait_idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Absolute time limit.
  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
